// File: rtl/seq_checker.sv
// Checker for an incrementing-word stream: hunts for the first word, then flags every word that is not previous+1.
// Define SEQ_CHECKER_CAPTURE_EN to latch the expected/received values at the first mismatch.
module seq_checker #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] ck_data,
  input  logic              ck_valid,
  output logic              ck_locked,
  output logic              ck_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  localparam int CONSEC_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);

  typedef enum logic [0:0] {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_exp, w_exp_nxt;
  logic [CONSEC_W-1:0] r_consec, w_consec_nxt;
  logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_nxt;
  logic [CNT_W-1:0]    r_rx_cnt, w_rx_cnt_nxt;
  logic                r_ck_err;
  logic                w_mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, next-expected and counter update for the word presented this cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_exp_nxt     = r_exp;
    w_consec_nxt  = r_consec;
    w_err_cnt_nxt = r_err_cnt;
    w_rx_cnt_nxt  = r_rx_cnt;
    w_mismatch    = 1'b0;
    if (clear) begin
      w_state_nxt   = HUNT;
      w_exp_nxt     = '0;
      w_consec_nxt  = '0;
      w_err_cnt_nxt = '0;
      w_rx_cnt_nxt  = '0;
    end else if (ck_valid) begin
      w_rx_cnt_nxt = sat_inc(r_rx_cnt);
      // Always resync on the received word so one dropped word costs one error.
      w_exp_nxt    = ck_data + DATA_W'(1);
      case (r_state)
        HUNT: begin
          w_state_nxt  = LOCK;
          w_consec_nxt = '0;
        end
        LOCK: begin
          if (ck_data != r_exp) begin
            w_mismatch    = 1'b1;
            w_err_cnt_nxt = sat_inc(r_err_cnt);
            if (r_consec == CONSEC_W'(LOSS_THRESH - 1)) begin
              w_state_nxt  = HUNT;
              w_consec_nxt = '0;
            end else begin
              w_consec_nxt = r_consec + CONSEC_W'(1);
            end
          end else begin
            w_consec_nxt = '0;
          end
        end
        default: begin
          w_state_nxt  = HUNT;
          w_consec_nxt = '0;
        end
      endcase
    end else begin
      w_mismatch = 1'b0;
    end
  end

  // Checker state and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= HUNT;
      r_exp     <= '0;
      r_consec  <= '0;
      r_err_cnt <= '0;
      r_rx_cnt  <= '0;
      r_ck_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp     <= w_exp_nxt;
      r_consec  <= w_consec_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_ck_err  <= w_mismatch;
    end
  end

  assign ck_locked = (r_state == LOCK);
  assign ck_err    = r_ck_err;
  assign err_cnt   = r_err_cnt;
  assign rx_cnt    = r_rx_cnt;

`ifdef SEQ_CHECKER_CAPTURE_EN
  logic [DATA_W-1:0] r_first_exp;
  logic [DATA_W-1:0] r_first_got;
  logic              r_captured;

  // First-mismatch capture; only clear or reset re-arms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first_exp <= '0;
      r_first_got <= '0;
      r_captured  <= 1'b0;
    end else if (clear) begin
      r_first_exp <= '0;
      r_first_got <= '0;
      r_captured  <= 1'b0;
    end else if (w_mismatch && !r_captured) begin
      r_first_exp <= r_exp;
      r_first_got <= ck_data;
      r_captured  <= 1'b1;
    end else begin
      r_captured  <= r_captured;
    end
  end

  assign first_err_exp = r_first_exp;
  assign first_err_got = r_first_got;
`else
  assign first_err_exp = '0;
  assign first_err_got = '0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: the driver pushes expected results, a monitor pops and compares them.
module tb_seq_checker;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int LOSS   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] ck_data = '0;
  logic              ck_valid = 1'b0;
  logic              ck_locked, ck_err;
  logic [CNT_W-1:0]  err_cnt, rx_cnt;
  logic [DATA_W-1:0] first_err_exp, first_err_got;

  seq_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LOSS_THRESH(LOSS)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ck_data(ck_data), .ck_valid(ck_valid),
    .ck_locked(ck_locked), .ck_err(ck_err), .err_cnt(err_cnt), .rx_cnt(rx_cnt),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              locked;
    logic              err;
    logic [CNT_W-1:0]  ecnt;
    logic [CNT_W-1:0]  rcnt;
    logic [DATA_W-1:0] fexp;
    logic [DATA_W-1:0] fgot;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  logic              m_locked = 1'b0;
  logic [DATA_W-1:0] m_exp = '0;
  int                m_consec = 0;
  logic [CNT_W-1:0]  m_ecnt = '0, m_rcnt = '0;
  logic              m_cap = 1'b0;
  logic [DATA_W-1:0] m_fexp = '0, m_fgot = '0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_exp = '0; m_consec = 0; m_ecnt = '0; m_rcnt = '0;
    m_cap = 1'b0; m_fexp = '0; m_fgot = '0;
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic c);
    exp_t e;
    logic err;
    @(negedge clk);
    ck_valid = v; ck_data = d; clear = c;
    err = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (m_rcnt != {CNT_W{1'b1}}) m_rcnt = m_rcnt + 1'b1;
      if (!m_locked) begin
        m_locked = 1'b1;
        m_consec = 0;
      end else if (d != m_exp) begin
        err = 1'b1;
        if (m_ecnt != {CNT_W{1'b1}}) m_ecnt = m_ecnt + 1'b1;
`ifdef SEQ_CHECKER_CAPTURE_EN
        if (!m_cap) begin m_cap = 1'b1; m_fexp = m_exp; m_fgot = d; end
`endif
        m_consec++;
        if (m_consec == LOSS) begin m_locked = 1'b0; m_consec = 0; end
      end else begin
        m_consec = 0;
      end
      m_exp = d + 1;
    end
    e.locked = m_locked; e.err = err; e.ecnt = m_ecnt; e.rcnt = m_rcnt;
    e.fexp = m_fexp; e.fgot = m_fgot;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  // Hand-computed end-of-test state, sampled mid-cycle after the last update.
  task automatic hand(input string t, input logic lk, input int ec, input int rc);
    @(posedge clk); #2;
    check({t, " locked"}, {31'd0, ck_locked}, {31'd0, lk});
    check({t, " err_cnt"}, {16'd0, err_cnt}, ec);
    check({t, " rx_cnt"}, {16'd0, rx_cnt}, rc);
  endtask

  // Monitor: each edge that retires a scoreboarded cycle is compared one step after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb locked", {31'd0, ck_locked}, {31'd0, e.locked});
      check("sb ck_err", {31'd0, ck_err}, {31'd0, e.err});
      check("sb err_cnt", {16'd0, err_cnt}, {16'd0, e.ecnt});
      check("sb rx_cnt", {16'd0, rx_cnt}, {16'd0, e.rcnt});
      check("sb first_err_exp", first_err_exp, e.fexp);
      check("sb first_err_got", first_err_got, e.fgot);
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    int w;
    #2;
    check("reset locked", {31'd0, ck_locked}, 32'd0);
    check("reset ck_err", {31'd0, ck_err}, 32'd0);
    check("reset err_cnt", {16'd0, err_cnt}, 32'd0);
    check("reset rx_cnt", {16'd0, rx_cnt}, 32'd0);
    check("reset first_err_exp", first_err_exp, 32'd0);
    @(negedge clk); rst = 1'b1;

    // 1: clean stream 0..99
    for (int i = 0; i < 100; i++) step(1'b1, DATA_W'(i), 1'b0);
    idle();
    hand("t1", 1'b1, 0, 100);

    // 2: wrap across all-ones
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      d = 32'hFFFF_FFFD + DATA_W'(i);
      step(1'b1, d, 1'b0);
    end
    idle();
    hand("t2", 1'b1, 0, 6);

    // 3: single drop
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'd10, 1'b0); step(1'b1, 32'd11, 1'b0);
    step(1'b1, 32'd13, 1'b0); step(1'b1, 32'd14, 1'b0);
    idle();
    hand("t3", 1'b1, 1, 4);
`ifdef SEQ_CHECKER_CAPTURE_EN
    check("t3 first_err_exp", first_err_exp, 32'd12);
    check("t3 first_err_got", first_err_got, 32'd13);
`else
    check("t3 first_err_exp", first_err_exp, 32'd0);
`endif

    // 4: loss of lock after LOSS consecutive errors, then relock
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'd5, 1'b0); step(1'b1, 32'd9, 1'b0); step(1'b1, 32'd20, 1'b0);
    step(1'b1, 32'd31, 1'b0); step(1'b1, 32'd42, 1'b0);
    idle();
    hand("t4a", 1'b0, 4, 5);
    step(1'b1, 32'd43, 1'b0); step(1'b1, 32'd44, 1'b0);
    idle();
    hand("t4b", 1'b1, 4, 7);

    // 5: clear outranks a valid word
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'd100, 1'b0); step(1'b1, 32'd101, 1'b0);
    step(1'b1, 32'd102, 1'b1);
    idle();
    hand("t5a", 1'b0, 0, 0);
    step(1'b1, 32'd500, 1'b0); step(1'b1, 32'd501, 1'b0);
    idle();
    hand("t5b", 1'b1, 0, 2);

    // 6: gapped stream with async reset at word 25
    step(1'b0, '0, 1'b1);
    w = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) begin
        idle();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("t6 async locked", {31'd0, ck_locked}, 32'd0);
        check("t6 async rx_cnt", {16'd0, rx_cnt}, 32'd0);
        check("t6 async err_cnt", {16'd0, err_cnt}, 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b1;
      end
      step(1'b1, DATA_W'(i), 1'b0);
      idle(); idle();
      w++;
    end
    hand("t6", 1'b1, 0, 25);

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    #3;
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
